// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register feeding an external sumador incrementer,
// synchronous imem read issue, and a 2-entry output FIFO with branch redirect.
module fetch_pc_unit #(
  parameter int unsigned          ADDR_W   = 12,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  add_a,
  output logic [ADDR_W-1:0]  add_b,
  input  logic [ADDR_W-1:0]  add_c,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic                inflight_q, inflight_d;
  logic                discard_q, discard_d;
  logic [1:0]          count_q, count_d;
  entry_t [1:0]        ent_q, ent_d;

  logic                deq, enq, redirect, credit_ok, wr_idx;
  logic [2:0]          occ;
  logic [1:0]          keep;

  assign add_a     = pc_q;
  assign add_b     = ADDR_W'(1);
  assign imem_addr = pc_q;

  assign out_valid = (count_q != 2'd0);
  assign out_instr = ent_q[0].instr;
  assign out_pc    = ent_q[0].pc;

  assign deq      = out_valid & out_ready;
  assign enq      = inflight_q & ~discard_q;
  assign redirect = (state_q == RUN) & branch_taken;

  // Credit: words held plus the one on its way back, less what leaves now.
  assign occ       = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, deq};
  assign credit_ok = (occ < 3'd2);
  assign imem_req  = (state_q == RUN) & en & ~branch_taken & credit_ok;

  assign keep   = count_q - {1'b0, deq};
  assign wr_idx = (keep != 2'd0);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = imem_req;
    discard_d  = 1'b0;
    req_pc_d   = imem_req ? pc_q : req_pc_q;
    case (state_q)
      IDLE: begin
        if (branch_taken) pc_d = branch_target;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          pc_d      = branch_target;
          state_d   = FLUSH;
          // Anything returning during the bubble belongs to the old path.
          discard_d = 1'b1;
        end else if (imem_req) begin
          pc_d = add_c;
        end
      end
      FLUSH: begin
        if (branch_taken) pc_d = branch_target;
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (redirect) begin
      count_d = 2'd0;
    end else begin
      if (deq) ent_d[0] = ent_q[1];
      if (enq) ent_d[wr_idx] = '{pc: req_pc_q, instr: imem_rdata};
      count_d = count_q + {1'b0, enq} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      count_q    <= 2'd0;
      ent_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      ent_q      <= ent_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: startup, backpressure, redirect, wrap,
// async reset mid-stream and fetch-enable stall.
module tb_fetch_pc_unit;

  logic        clk, rst, en, branch_taken, out_ready;
  logic [11:0] branch_target, add_a, add_b, add_c, imem_addr, out_pc;
  logic        imem_req, out_valid;
  logic [31:0] imem_rdata, out_instr;

  int n_vec = 0;
  int n_err = 0;

  fetch_pc_unit #(.ADDR_W(12), .INSTR_W(32), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst), .en(en),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  // sumador and synchronous instruction memory
  assign add_c = add_a + add_b;
  initial imem_rdata = 32'h0;
  always @(posedge clk) if (imem_req) imem_rdata <= 32'hA000 + {20'b0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; branch_taken = 1'b0; branch_target = 12'h000; out_ready = 1'b1;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_req",   imem_req, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc",    out_pc, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 1);

    tick(); rst = 1'b0; en = 1'b1; #1;
    chk("idle_req", imem_req, 0);

    // Startup latency
    tick();
    chk("e0_req", imem_req, 1); chk("e0_addr", imem_addr, 12'h000); chk("e0_valid", out_valid, 0);
    tick();
    chk("e1_req", imem_req, 1); chk("e1_addr", imem_addr, 12'h001); chk("e1_valid", out_valid, 0);
    tick();
    chk("e2_valid", out_valid, 1); chk("e2_pc", out_pc, 12'h000); chk("e2_instr", out_instr, 32'hA000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_valid", out_valid, 1); chk("seq_pc", out_pc, i); chk("seq_instr", out_instr, 32'hA000 + i);
    end

    // Backpressure for 3 cycles
    out_ready = 1'b0; #1;
    chk("bp_req_drop", imem_req, 0); chk("bp_hold_pc", out_pc, 12'h003);
    tick();
    chk("bp_full_req", imem_req, 0); chk("bp_full_valid", out_valid, 1); chk("bp_full_pc", out_pc, 12'h003);
    tick();
    chk("bp_full_req2", imem_req, 0);
    tick(); out_ready = 1'b1; #1;
    chk("bp_resume_req", imem_req, 1); chk("bp_resume_addr", imem_addr, 12'h005); chk("bp_head", out_pc, 12'h003);
    for (int i = 4; i <= 6; i++) begin
      tick();
      chk("bp_seq_valid", out_valid, 1); chk("bp_seq_pc", out_pc, i); chk("bp_seq_instr", out_instr, 32'hA000 + i);
    end

    // Redirect with one word buffered and one inflight
    branch_taken = 1'b1; branch_target = 12'h100; #1;
    chk("br_req", imem_req, 0); chk("br_valid_now", out_valid, 1);
    tick(); branch_taken = 1'b0; #1;
    chk("br_flush_valid", out_valid, 0); chk("br_flush_req", imem_req, 0); chk("br_flush_addr", imem_addr, 12'h100);
    tick();
    chk("br_run_valid", out_valid, 0); chk("br_run_req", imem_req, 1); chk("br_run_addr", imem_addr, 12'h100);
    tick();
    chk("br_no_stale", out_valid, 0);
    tick();
    chk("br_first_pc", out_pc, 12'h100); chk("br_first_instr", out_instr, 32'hA100);
    tick();
    chk("br_second_pc", out_pc, 12'h101); chk("br_second_instr", out_instr, 32'hA101);

    // Wrap-around
    branch_taken = 1'b1; branch_target = 12'hFFE;
    tick(); branch_taken = 1'b0;
    tick();
    chk("wr_req", imem_req, 1); chk("wr_add_a0", add_a, 12'hFFE);
    tick();
    chk("wr_add_a", add_a, 12'hFFF); chk("wr_add_b", add_b, 12'h001);
    tick();
    chk("wr_pc0", out_pc, 12'hFFE); chk("wr_instr0", out_instr, 32'hAFFE);
    tick();
    chk("wr_pc1", out_pc, 12'hFFF); chk("wr_instr1", out_instr, 32'hAFFF);
    tick();
    chk("wr_pc2", out_pc, 12'h000); chk("wr_instr2", out_instr, 32'hA000); chk("wr_valid2", out_valid, 1);

    // Fill FIFO, then async reset between edges
    out_ready = 1'b0;
    tick();
    chk("ar_full_valid", out_valid, 1); chk("ar_full_req", imem_req, 0);
    #2 rst = 1'b1; #1;
    chk("ar_valid", out_valid, 0); chk("ar_req", imem_req, 0); chk("ar_pc", imem_addr, 12'h000);
    #1 rst = 1'b0;
    tick(); out_ready = 1'b1; #1;
    chk("ar_restart_req", imem_req, 1); chk("ar_restart_addr", imem_addr, 12'h000);
    tick();
    chk("ar_addr1", imem_addr, 12'h001);
    tick();
    chk("ar_out_valid", out_valid, 1); chk("ar_out_pc", out_pc, 12'h000); chk("ar_out_instr", out_instr, 32'hA000);

    // Fetch enable low for 2 cycles
    en = 1'b0; #1;
    chk("en0_req", imem_req, 0);
    tick();
    chk("en0_req2", imem_req, 0); chk("en0_pc_held", imem_addr, 12'h002);
    chk("en0_drain_pc", out_pc, 12'h001); chk("en0_drain_instr", out_instr, 32'hA001);
    tick(); en = 1'b1; #1;
    chk("en1_empty", out_valid, 0); chk("en1_req", imem_req, 1); chk("en1_addr", imem_addr, 12'h002);
    tick();
    tick();
    chk("en1_pc2", out_pc, 12'h002); chk("en1_instr2", out_instr, 32'hA002);
    tick();
    chk("en1_pc3", out_pc, 12'h003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
